// File: rtl/dsp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_pkg
// Description : Shared types and constants for the DSP MAC job sequencer.
//               Holds the sequencer state encoding, the slice opmode words,
//               the fixed slice pipeline latency and an opmode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_seq_pkg;

    // Sequencer state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Z=0, X=M : start a fresh accumulation with the first product
    localparam logic [7:0] OPM_FIRST   = 8'h01;
    // Z=P, X=M : accumulate onto the current P
    localparam logic [7:0] OPM_ACC     = 8'h09;
    // Post-adder subtract select
    localparam int         OPM_SUB_BIT = 7;
    // Beat accept -> P update, set by A1/B1, M and P registers
    localparam int         DSP_PIPE_LAT = 3;

    // Opmode word for a beat in stage 1
    function automatic logic [7:0] opmode_for(input logic first, input logic sub);
        logic [7:0] m;
        m = first ? OPM_FIRST : OPM_ACC;
        m[OPM_SUB_BIT] = sub;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_seq_tagpipe.sv
`default_nettype none
// ============================================================================
// Module      : dsp_seq_tagpipe
// Description : Tag shift register that travels alongside beats inside the
//               DSP slice pipeline. A valid/last tag pair per stage plus a
//               first tag for stage 1 (the only stage that needs it).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               fire             - beat accepted this cycle
//               first, last      - tags of the accepted beat
//               s1_valid/s1_first- stage 1 tags (drive CEM/CEOPMODE/opmode)
//               s2_valid         - stage 2 valid (drives CEP)
//               last_done        - last beat of the job has reached P
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_seq_tagpipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic first,
    input  logic last,
    output logic s1_valid,
    output logic s1_first,
    output logic s2_valid,
    output logic last_done
);

    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_l;
    logic             r_f;

    // Tags shift every cycle; a bubble shifts in a cleared valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_l <= '0;
            r_f <= 1'b0;
        end else begin
            r_v <= {r_v[DEPTH-2:0], fire};
            r_l <= {r_l[DEPTH-2:0], fire & last};
            r_f <= fire & first;
        end
    end

    assign s1_valid  = r_v[0];
    assign s1_first  = r_f;
    assign s2_valid  = r_v[1];
    assign last_done = r_v[DEPTH-1] & r_l[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_sequencer
// Description : Job sequencer driving one DSP48A1-style slice as a MAC.
//               Accepts a job (start/len/sub) and a stream of 18-bit (a,b)
//               beats, steers slice CE/opmode so P = +/- sum(a*b), and
//               captures the final P into a handshaked result register.
// Ports       : clk, RST                      - clock, sync active-high reset
//               start, len, sub               - job request (sampled in IDLE)
//               in_valid/in_ready/in_a/in_b   - beat stream
//               res_valid/res_ready/res_data  - result handshake
//               busy                          - not IDLE
//               dsp_*                         - slice control / data / P
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = DSP_PIPE_LAT
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_ceopmode,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);

    seq_state_e       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_sub;
    logic             r_first;
    logic [47:0]      r_res_data;

    logic w_in_ready;
    logic w_fire;
    logic w_last;
    logic w_s1_valid;
    logic w_s1_first;
    logic w_s2_valid;
    logic w_last_done;

    // Outputs are gated by RST so the very first reset cycle is already quiet
    assign w_in_ready = !RST && (r_state == ST_RUN) && (r_cnt != '0);
    assign w_fire     = in_valid && w_in_ready;
    assign w_last     = (r_cnt == LEN_W'(1));

    dsp_seq_tagpipe #(
        .DEPTH (PIPE_LAT)
    ) u_tagpipe (
        .clk       (clk),
        .rst       (RST),
        .fire      (w_fire),
        .first     (r_first),
        .last      (w_last),
        .s1_valid  (w_s1_valid),
        .s1_first  (w_s1_first),
        .s2_valid  (w_s2_valid),
        .last_done (w_last_done)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sub      <= 1'b0;
            r_first    <= 1'b0;
            r_res_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sub <= sub;
                        if (len != '0) begin
                            r_cnt   <= len;
                            r_first <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            r_res_data <= '0;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        r_cnt   <= r_cnt - LEN_W'(1);
                        r_first <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // P now holds the full sum including the tagged last beat
                    if (w_last_done) begin
                        r_res_data <= dsp_p;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign res_valid    = !RST && (r_state == ST_DONE);
    assign res_data     = r_res_data;
    assign busy         = !RST && (r_state != ST_IDLE);

    assign dsp_a        = in_a;
    assign dsp_b        = in_b;
    assign dsp_cea      = w_fire;
    assign dsp_ceb      = w_fire;
    assign dsp_cem      = !RST && w_s1_valid;
    assign dsp_ceopmode = !RST && w_s1_valid;
    assign dsp_cep      = !RST && w_s2_valid;
    // The first beat uses Z=0, which discards any previous job's P
    assign dsp_opmode   = (!RST && w_s1_valid) ? opmode_for(w_s1_first, r_sub) : 8'h00;
    assign dsp_rst      = RST;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mac_sequencer
// Description : Self-checking bench for dsp_mac_sequencer with a behavioural
//               slice model (A1/B1, M, OPMODE and P registers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] len;
    logic        sub;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        busy;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_ceopmode, dsp_cem, dsp_cep, dsp_rst;
    logic [47:0] dsp_p;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(16), .PIPE_LAT(3)) dut (
        .clk          (clk),
        .RST          (RST),
        .start        (start),
        .len          (len),
        .sub          (sub),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_cea      (dsp_cea),
        .dsp_ceb      (dsp_ceb),
        .dsp_ceopmode (dsp_ceopmode),
        .dsp_cem      (dsp_cem),
        .dsp_cep      (dsp_cep),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p)
    );

    // ---------------- slice model ----------------
    logic [17:0] m_a1, m_b1;
    logic [35:0] m_m;
    logic [7:0]  m_opm;
    logic [47:0] m_p;
    logic [47:0] m_z, m_x;

    assign m_z   = (m_opm[3:2] == 2'b10) ? m_p : 48'd0;
    assign m_x   = (m_opm[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0;
    assign dsp_p = m_p;

    always @(posedge clk) begin
        if (dsp_rst) begin
            m_a1  <= '0;
            m_b1  <= '0;
            m_m   <= '0;
            m_opm <= '0;
            m_p   <= '0;
        end else begin
            if (dsp_cea)      m_a1  <= dsp_a;
            if (dsp_ceb)      m_b1  <= dsp_b;
            if (dsp_cem)      m_m   <= {18'd0, m_a1} * {18'd0, m_b1};
            if (dsp_ceopmode) m_opm <= dsp_opmode;
            if (dsp_cep)      m_p   <= m_opm[7] ? (m_z - m_x) : (m_z + m_x);
        end
    end

    // ---------------- bookkeeping ----------------
    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int ev_cyc = 0;

    typedef struct {
        logic [47:0] data;
        int          lat;
    } exp_t;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- result monitor ----------------
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (RST) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    check("result_latency", 64'(cyc - ev_cyc), 64'(q[0].lat));
                end
            end
            if (res_valid && res_ready && q.size() != 0) begin
                e = q.pop_front();
                check("result_data", 64'(res_data), 64'(e.data));
            end
            prev_v = res_valid;
        end
    end

    // ---------------- slice enable monitor ----------------
    logic fire_s = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0;
    always @(negedge clk) begin
        fire_s = in_valid & in_ready;
        if (!RST) begin
            check("ce_pipeline", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep}),
                  64'({fire_s, fire_s, h1, h1, h2}));
        end
    end
    always @(posedge clk) begin
        if (RST) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
        end else begin
            h1 <= fire_s;
            h2 <= h1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_outputs", 64'({in_ready, res_valid, busy, dsp_cea, dsp_ceb,
                                      dsp_cem, dsp_ceopmode, dsp_cep, dsp_rst}), 64'h001);
            check("rst_opmode", 64'(dsp_opmode), 64'd0);
            if (i == n - 1) check("rst_res_data", 64'(res_data), 64'd0);
            tick();
        end
        RST = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_job(input int l, input bit s, input bit push,
                             input logic [47:0] exp, input int lat);
        exp_t e;
        wait_idle();
        start = 1'b1;
        len   = 16'(l);
        sub   = s;
        if (push) begin
            e.data = exp;
            e.lat  = lat;
            q.push_back(e);
        end
        ev_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic [17:0] a, input logic [17:0] b, input int gap);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc    = 1'b1;
                ev_cyc = cyc;
            end
            tick();
        end
        if (!acc) check("beat_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        bit seen;
        RST = 1'b1; start = 1'b0; len = '0; sub = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
        tick();
        do_reset(3);

        // 1: back-to-back beats, 2*3+4*5+6*7 = 68
        start_job(3, 1'b0, 1'b1, 48'd68, 4);
        beat(18'd2, 18'd3, 0);
        beat(18'd4, 18'd5, 0);
        beat(18'd6, 18'd7, 0);

        // 2: same job with bubbles between beats
        start_job(3, 1'b0, 1'b1, 48'd68, 4);
        beat(18'd2, 18'd3, 2);
        beat(18'd4, 18'd5, 2);
        beat(18'd6, 18'd7, 2);

        // 3: subtract, -(100+1)
        start_job(2, 1'b1, 1'b1, 48'hFFFF_FFFF_FF9B, 4);
        beat(18'd10, 18'd10, 0);
        beat(18'd1, 18'd1, 0);

        // 4: empty job
        start_job(0, 1'b0, 1'b1, 48'd0, 1);

        // 5: result held while res_ready is low; start ignored in DONE
        wait_idle();
        res_ready = 1'b0;
        start_job(1, 1'b0, 1'b1, 48'd25, 4);
        beat(18'd5, 18'd5, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("hold_seen_valid", 64'(res_valid), 64'd1);
        start = 1'b1;
        len   = 16'd2;
        for (int k = 0; k < 5; k++) begin
            check("hold_state", 64'({res_valid, in_ready, busy}), 64'b101);
            check("hold_data", 64'(res_data), 64'd25);
            @(negedge clk);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("after_accept_idle", 64'({busy, res_valid}), 64'b00);

        // 6: abandon a job with reset, then full-scale and fresh jobs
        start_job(4, 1'b0, 1'b0, 48'd0, 0);
        beat(18'd7, 18'd9, 0);
        beat(18'd8, 18'd9, 0);
        do_reset(2);
        repeat (6) tick();
        check("abort_idle", 64'({busy, res_valid}), 64'b00);
        start_job(1, 1'b0, 1'b1, 48'h000F_FFF8_0001, 4);
        beat(18'h3FFFF, 18'h3FFFF, 0);
        start_job(1, 1'b0, 1'b1, 48'd1, 4);
        beat(18'd1, 18'd1, 0);

        wait_idle();
        repeat (5) tick();
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
        $fatal(1);
    end

endmodule
`default_nettype wire
